// File: rtl/common_pkg.sv
// Shared bus-width constants for the Wishbone fabric.
package common_pkg;

  parameter int unsigned DATA_WIDTH = 8;

endpackage

// File: rtl/wb_cmd_master.sv
// Wishbone B4 pipelined master: runs one read or fill burst per command, one beat
// outstanding at a time, streaming read data back and aborting a beat on ack timeout.
module wb_cmd_master
  import common_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                  wb_clock_i,
  input  logic                  wb_reset_i,

  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [DATA_WIDTH-1:0] cmd_data_i,
  input  logic                  cmd_we_i,
  input  logic [7:0]            cmd_len_i,

  output logic                  rd_valid_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  done_o,
  output logic                  err_o,

  output logic [ADDR_WIDTH-1:0] wb_addr_o,
  output logic [DATA_WIDTH-1:0] wb_data_o,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  output logic                  wb_we_o,
  output logic                  wb_cycle_o,
  output logic                  wb_strobe_o,
  input  logic                  wb_stall_i,
  input  logic                  wb_ack_i
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    StIdle,
    StStrobe,
    StWaitAck
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  we_q, we_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            beat_q, beat_d;
  logic [TmoW-1:0]       tmo_q, tmo_d;
  logic                  cyc_q, cyc_d;
  logic                  stb_q, stb_d;
  logic                  ready_q, ready_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  beat_ack;
  logic                  tmo_hit;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    we_d       = we_q;
    len_d      = len_q;
    beat_d     = beat_q;
    tmo_d      = tmo_q;
    cyc_d      = cyc_q;
    stb_d      = stb_q;
    ready_d    = ready_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    beat_ack   = 1'b0;
    // Last cycle this beat may spend waiting; an ack on this same edge still wins.
    tmo_hit    = (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

    case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          state_d = StStrobe;
          addr_d  = cmd_addr_i;
          wdata_d = cmd_data_i;
          we_d    = cmd_we_i;
          len_d   = cmd_len_i;
          beat_d  = 8'd0;
          tmo_d   = '0;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          ready_d = 1'b0;
        end
      end

      StStrobe, StWaitAck: begin
        // Ack only counts once the strobe has been (or is being) accepted.
        beat_ack = wb_ack_i && ((state_q == StWaitAck) || !wb_stall_i);
        if (beat_ack) begin
          if (!we_q) begin
            rd_valid_d = 1'b1;
            rdata_d    = wb_data_i;
          end
          if (beat_q == len_q) begin
            state_d = StIdle;
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            we_d    = 1'b0;
            ready_d = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d = StStrobe;
            stb_d   = 1'b1;
            addr_d  = addr_q + 1'b1;
            beat_d  = beat_q + 8'd1;
            tmo_d   = '0;
          end
        end else if (tmo_hit) begin
          state_d = StIdle;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          ready_d = 1'b1;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
          if ((state_q == StStrobe) && !wb_stall_i) begin
            state_d = StWaitAck;
            stb_d   = 1'b0;
          end
        end
      end

      default: begin
        state_d = StIdle;
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge wb_clock_i) begin
    if (wb_reset_i) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      we_q       <= 1'b0;
      len_q      <= 8'd0;
      beat_q     <= 8'd0;
      tmo_q      <= '0;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      ready_q    <= 1'b1;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      we_q       <= we_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      tmo_q      <= tmo_d;
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      ready_q    <= ready_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign cmd_ready_o = ready_q;
  assign rd_valid_o  = rd_valid_q;
  assign rd_data_o   = rdata_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign wb_addr_o   = addr_q;
  assign wb_data_o   = wdata_q;
  assign wb_we_o     = we_q;
  assign wb_cycle_o  = cyc_q;
  assign wb_strobe_o = stb_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Randomised scoreboard bench for wb_cmd_master with a scripted Wishbone slave and a
// burst-level reference model (memory image, per-beat stall/ack plan, expected latency).
module tb_wb_cmd_master;

  localparam int unsigned AW  = 16;
  localparam int unsigned DW  = common_pkg::DATA_WIDTH;
  localparam int unsigned TMO = 15;

  logic          wb_clock_i;
  logic          wb_reset_i;
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic [AW-1:0] cmd_addr_i;
  logic [DW-1:0] cmd_data_i;
  logic          cmd_we_i;
  logic [7:0]    cmd_len_i;
  logic          rd_valid_o;
  logic [DW-1:0] rd_data_o;
  logic          done_o;
  logic          err_o;
  logic [AW-1:0] wb_addr_o;
  logic [DW-1:0] wb_data_o;
  logic [DW-1:0] wb_data_i;
  logic          wb_we_o;
  logic          wb_cycle_o;
  logic          wb_strobe_o;
  logic          wb_stall_i;
  logic          wb_ack_i;

  wb_cmd_master #(
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .wb_clock_i (wb_clock_i),
    .wb_reset_i (wb_reset_i),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .cmd_addr_i (cmd_addr_i),
    .cmd_data_i (cmd_data_i),
    .cmd_we_i   (cmd_we_i),
    .cmd_len_i  (cmd_len_i),
    .rd_valid_o (rd_valid_o),
    .rd_data_o  (rd_data_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .wb_addr_o  (wb_addr_o),
    .wb_data_o  (wb_data_o),
    .wb_data_i  (wb_data_i),
    .wb_we_o    (wb_we_o),
    .wb_cycle_o (wb_cycle_o),
    .wb_strobe_o(wb_strobe_o),
    .wb_stall_i (wb_stall_i),
    .wb_ack_i   (wb_ack_i)
  );

  initial wb_clock_i = 1'b0;
  always #5 wb_clock_i = ~wb_clock_i;

  // Per-beat slave behaviour: s stall cycles, then ack d cycles after acceptance
  // (d = 0 acks on the accepting edge, d < 0 never acks).
  typedef struct {
    int s;
    int d;
  } beat_plan_t;

  beat_plan_t       plan[$];
  logic [DW-1:0]    exp_rd[$];
  logic [AW+DW-1:0] exp_wr[$];
  bit               exp_end[$];
  int               exp_lat[$];

  logic [DW-1:0] mem     [0:65535];
  logic [DW-1:0] ref_mem [0:65535];

  int checks  = 0;
  int errors  = 0;
  int wr_cnt  = 0;
  int stb_cnt = 0;
  int end_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Model a whole burst up front, then present the command until it is taken.
  task automatic issue(input logic [AW-1:0] a, input logic [DW-1:0] dt, input bit we,
                       input int len, input int mode, input int xb, input int xs,
                       input int xd, input bit hold);
    int            total;
    int            guard;
    beat_plan_t    p;
    logic [AW-1:0] aa;
    total = 0;
    for (int i = 0; i <= len; i++) begin
      aa  = a + AW'(i);
      p.s = 0;
      p.d = 1;
      if (mode == 1) begin
        p.s = int'($urandom_range(0, 4));
        p.d = int'($urandom_range(0, 4));
      end else if (mode == 2) begin
        p.d = -1;
      end
      if (i == xb) begin
        p.s = xs;
        p.d = xd;
      end
      plan.push_back(p);
      total += p.s + 1 + p.d;
      if (mode != 2) begin
        if (we) begin
          exp_wr.push_back({aa, dt});
          ref_mem[aa] = dt;
        end else begin
          exp_rd.push_back(ref_mem[aa]);
        end
      end
    end
    exp_end.push_back(mode == 2);
    exp_lat.push_back((mode == 2) ? int'(TMO) + 1 : total + 1);

    cmd_addr_i  = a;
    cmd_data_i  = dt;
    cmd_we_i    = we;
    cmd_len_i   = 8'(len);
    cmd_valid_i = 1'b1;
    guard = 0;
    do begin
      @(negedge wb_clock_i);
      guard++;
    end while (!cmd_ready_o && guard < 3000);
    if (!cmd_ready_o) fail_now("cmd_accept_timeout");
    @(posedge wb_clock_i);
    #1;
    if (!hold) cmd_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((exp_end.size() != 0) && guard < 5000) begin
      @(negedge wb_clock_i);
      guard++;
    end
    if (exp_end.size() != 0) fail_now("burst_end_timeout");
    @(posedge wb_clock_i);
    #1;
  endtask

  // Slave: drives stall/ack/data at negedge for the coming posedge.
  initial begin : slave
    bit               in_beat;
    bit               pend;
    int               s_left;
    int               d_cur;
    int               d_left;
    logic [DW-1:0]    rdat;
    logic [AW-1:0]    a_first;
    logic [AW+DW-1:0] w;
    beat_plan_t       p;
    in_beat    = 1'b0;
    pend       = 1'b0;
    s_left     = 0;
    d_cur      = 1;
    d_left     = 0;
    rdat       = '0;
    a_first    = '0;
    wb_stall_i = 1'b0;
    wb_ack_i   = 1'b0;
    wb_data_i  = '0;
    forever begin
      @(negedge wb_clock_i);
      wb_ack_i   = 1'b0;
      wb_stall_i = 1'b0;
      if (wb_reset_i) begin
        in_beat = 1'b0;
        pend    = 1'b0;
      end else if (pend) begin
        if (d_left == 0) begin
          wb_ack_i  = 1'b1;
          wb_data_i = rdat;
          pend      = 1'b0;
        end else begin
          d_left--;
        end
      end else if (wb_cycle_o && wb_strobe_o) begin
        if (!in_beat) begin
          in_beat = 1'b1;
          a_first = wb_addr_o;
          if (plan.size() == 0) begin
            fail_now("unplanned_strobe");
            p.s = 0;
            p.d = 1;
          end else begin
            p = plan.pop_front();
          end
          s_left = p.s;
          d_cur  = p.d;
        end
        if (s_left > 0) begin
          wb_stall_i = 1'b1;
          s_left--;
        end else begin
          in_beat = 1'b0;
          check("stb_addr_stable", 32'(wb_addr_o), 32'(a_first));
          if (wb_we_o) begin
            wr_cnt++;
            mem[wb_addr_o] = wb_data_o;
            if (exp_wr.size() == 0) begin
              fail_now("unexpected_write");
            end else begin
              w = exp_wr.pop_front();
              check("write_{addr,data}", 32'({wb_addr_o, wb_data_o}), 32'(w));
            end
          end else begin
            rdat = mem[wb_addr_o];
          end
          if (d_cur == 0) begin
            wb_ack_i  = 1'b1;
            wb_data_i = rdat;
          end else if (d_cur > 0) begin
            pend   = 1'b1;
            d_left = d_cur - 1;
          end
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents read data or a burst end.
  initial begin : monitor
    int ncyc;
    int acc_cyc;
    bit e;
    int l;
    ncyc    = 0;
    acc_cyc = 0;
    forever begin
      @(negedge wb_clock_i);
      ncyc++;
      if (wb_strobe_o) stb_cnt++;
      if (rd_valid_o) begin
        if (exp_rd.size() == 0) fail_now("unexpected_rd_valid");
        else check("rd_data", 32'(rd_data_o), 32'(exp_rd.pop_front()));
      end
      if (done_o || err_o) begin
        end_cnt++;
        if (exp_end.size() == 0) begin
          fail_now("unexpected_done_or_err");
        end else begin
          e = exp_end.pop_front();
          l = exp_lat.pop_front();
          check("end_kind_{done,err}", 32'({done_o, err_o}), e ? 32'd1 : 32'd2);
          check("burst_latency", 32'(ncyc - acc_cyc), 32'(l));
          check("idle_at_end_{ready,cyc,stb}", 32'({cmd_ready_o, wb_cycle_o, wb_strobe_o}),
                32'd4);
        end
      end
      if (cmd_valid_i && cmd_ready_o && !wb_reset_i) acc_cyc = ncyc;
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL global_watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [DW-1:0] v;
    int            s0;
    int            w0;
    int            w1;
    int            e0;
    int            g;
    int            ln;
    bit            hd;
    wb_reset_i  = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_addr_i  = '0;
    cmd_data_i  = '0;
    cmd_we_i    = 1'b0;
    cmd_len_i   = 8'd0;
    for (int i = 0; i < 65536; i++) begin
      v          = DW'($urandom);
      mem[i]     = v;
      ref_mem[i] = v;
    end
    mem[16'h0100]     = 8'hA5;
    ref_mem[16'h0100] = 8'hA5;

    repeat (3) @(posedge wb_clock_i);
    @(negedge wb_clock_i);
    check("reset_ready", 32'(cmd_ready_o), 32'd1);
    check("reset_{cyc,stb,we}", 32'({wb_cycle_o, wb_strobe_o, wb_we_o}), 32'd0);
    check("reset_{rd_valid,done,err}", 32'({rd_valid_o, done_o, err_o}), 32'd0);
    check("reset_{addr,wdata,rdata}", 32'({wb_addr_o, wb_data_o, rd_data_o}), 32'd0);
    @(posedge wb_clock_i);
    #1;
    wb_reset_i = 1'b0;

    // Single read of 8'hA5.
    s0 = stb_cnt;
    issue(16'h0100, 8'h00, 1'b0, 0, 0, -1, 0, 0, 1'b0);
    wait_idle();
    check("single_read_stb_cycles", 32'(stb_cnt - s0), 32'd1);

    // Fill across the address wrap.
    s0 = stb_cnt;
    issue(16'hFFFE, 8'h20, 1'b1, 3, 0, -1, 0, 0, 1'b0);
    wait_idle();
    check("fill_wrap_stb_cycles", 32'(stb_cnt - s0), 32'd4);

    // Three stall cycles on beat 2 of a 3-beat read.
    s0 = stb_cnt;
    issue(16'h0200, 8'h00, 1'b0, 2, 0, 1, 3, 1, 1'b0);
    wait_idle();
    check("stall_read_stb_cycles", 32'(stb_cnt - s0), 32'd6);

    // Ack on the final allowed cycle wins over the timeout.
    issue(16'h0300, 8'h00, 1'b0, 0, 0, 0, 0, int'(TMO) - 1, 1'b0);
    wait_idle();
    issue(16'h0301, 8'h00, 1'b0, 0, 0, 0, int'(TMO) - 1, 0, 1'b0);
    wait_idle();

    // Slave never acks, then a normal read recovers.
    issue(16'h0400, 8'h00, 1'b0, 0, 2, -1, 0, 0, 1'b0);
    wait_idle();
    issue(16'h0100, 8'h00, 1'b0, 0, 0, -1, 0, 0, 1'b0);
    wait_idle();

    // Back-to-back with cmd_valid_i held.
    issue(16'h0500, 8'h33, 1'b1, 1, 0, -1, 0, 0, 1'b1);
    issue(16'h0500, 8'h00, 1'b0, 1, 0, -1, 0, 0, 1'b0);
    wait_idle();

    // Randomised bursts under a randomised slave.
    for (int n = 0; n < 40; n++) begin
      ln = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) :
                                         int'($urandom_range(0, 7));
      hd = (n < 39) ? bit'($urandom_range(0, 1)) : 1'b0;
      issue(AW'($urandom), DW'($urandom), bit'($urandom_range(0, 1)), ln, 1, -1, 0, 0, hd);
    end
    wait_idle();

    // Reset during beat 5 of a 256-beat fill.
    issue(16'h8000, 8'h5A, 1'b1, 255, 0, -1, 0, 0, 1'b0);
    w0 = wr_cnt - 1;
    g  = 0;
    while (wr_cnt < w0 + 5 && g < 200) begin
      @(negedge wb_clock_i);
      g++;
    end
    if (wr_cnt < w0 + 5) fail_now("midburst_writes_timeout");
    @(posedge wb_clock_i);
    #1;
    e0 = end_cnt;
    w1 = wr_cnt;
    wb_reset_i = 1'b1;
    @(posedge wb_clock_i);
    #1;
    wb_reset_i = 1'b0;
    exp_wr.delete();
    exp_rd.delete();
    exp_end.delete();
    exp_lat.delete();
    plan.delete();
    @(negedge wb_clock_i);
    check("midburst_reset_{ready,cyc,stb}", 32'({cmd_ready_o, wb_cycle_o, wb_strobe_o}),
          32'd4);
    repeat (30) @(negedge wb_clock_i);
    check("no_writes_after_reset", 32'(wr_cnt - w1), 32'd0);
    check("no_end_pulse_after_reset", 32'(end_cnt - e0), 32'd0);
    @(posedge wb_clock_i);
    #1;

    issue(16'h0100, 8'h00, 1'b0, 0, 0, -1, 0, 0, 1'b0);
    wait_idle();
    check("queues_drained", 32'(exp_rd.size() + exp_wr.size() + plan.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
